// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer.
// It samples each bit at mid-bit and delivers bytes through a one-entry
// holding register. Reports stop-bit framing errors and dropped bytes.
//
// Handshake: valid stays high while the holding register contains an
// unacknowledged byte. The transfer completes on any rising clock edge
// where valid && ack. ack is ignored while valid is low. A byte that
// completes in the same cycle as an ack replaces the accepted byte, and
// valid stays high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_meta_q, rx_s_q;

  // Two-flop synchronizer. It resets to the idle-high line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state, bit timing, shifting and holding-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    // The consumer takes the byte. A load in the STOP branch below can override this.
    if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (!valid_q || ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must not look like a fresh start bit.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued when a frame is driven. They are popped and
// compared when the DUT loads its holding register.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // Clock and free-running cycle counter
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Output monitor. It samples on the falling edge, away from the active edge.
  int         load_cnt   = 0;
  logic [7:0] load_data  = 8'h00;
  int         rise_cyc   = 0;
  int         fe_cycles  = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  always @(negedge clock) begin
    if (valid && (!valid_prev || data != data_prev)) begin
      load_cnt  <= load_cnt + 1;
      load_data <= data;
    end
    if (valid && !valid_prev) rise_cyc <= cyc;
    if (frame_err) fe_cycles <= fe_cycles + 1;
    valid_prev <= valid;
    data_prev  <= data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting just after a rising edge. ncyc can cut the
  // frame short. ack is raised for the one cycle sampled by edge ack_edge
  // after the start. An ack_edge of 0 means no ack is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ack_edge, input int ncyc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      rx  = bits[i / CPB];
      ack = (i == ack_edge - 1);
      @(posedge clock);
      #1;
    end
    ack = 1'b0;
  endtask

  int consumed = 0;

  // Waits (bounded) for the next holding-register load. Then it checks the byte against the scoreboard.
  task automatic expect_load(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 300 && load_cnt == consumed; i++) begin
      @(posedge clock);
      #1;
    end
    chk({tag, "_load_seen"}, 32'(load_cnt > consumed), 32'd1);
    if (load_cnt > consumed) begin
      consumed++;
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, 32'(load_data), 32'(e));
      end
    end
  endtask

  task automatic ack_pulse(input string tag);
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    chk({tag, "_valid_after_ack"}, 32'(valid), 32'd0);
    chk({tag, "_overrun_after_ack"}, 32'(overrun), 32'd0);
  endtask

  int c0;
  int fe0;
  int lat;

  initial begin
    // Reset
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    // Frame 0x47: latency of valid, then ack
    c0 = cyc;
    exp_q.push_back(8'h47);
    send_frame(8'h47, 1'b1, 0, 10 * CPB);
    expect_load("f47");
    lat = rise_cyc - c0;
    chk("f47_latency_window", 32'(lat >= 154 && lat <= 157), 32'd1);
    chk("f47_valid", 32'(valid), 32'd1);
    chk("f47_frame_err_cnt", 32'(fe_cycles), 32'd0);
    chk("f47_overrun", 32'(overrun), 32'd0);
    ack_pulse("f47");
    repeat (3) @(posedge clock);
    #1;
    chk("f47_ack_idle_valid", 32'(valid), 32'd0);

    // Three-cycle glitch is rejected
    rx = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("glitch_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("glitch_valid", 32'(valid), 32'd0);
    chk("glitch_frame_err_cnt", 32'(fe_cycles), 32'd0);
    chk("glitch_no_load", 32'(load_cnt), 32'(consumed));
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0, 10 * CPB);
    expect_load("fa5");
    ack_pulse("fa5");

    // Framing error followed by a held-low break
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0, 0, 10 * CPB);
    repeat (40) @(posedge clock);
    #1;
    chk("brk_state_low", 32'(state_dbg), 32'(ST_BREAK));
    rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("brk_frame_err_cycles", 32'(fe_cycles - fe0), 32'd1);
    chk("brk_valid", 32'(valid), 32'd0);
    chk("brk_no_load", 32'(load_cnt), 32'(consumed));
    chk("brk_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0, 10 * CPB);
    expect_load("f55");
    ack_pulse("f55");

    // Overrun: two back-to-back frames with no ack
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0, 10 * CPB);
    expect_load("ovr12");
    send_frame(8'h34, 1'b1, 0, 10 * CPB);
    chk("ovr_data_kept", 32'(data), 32'h12);
    chk("ovr_valid", 32'(valid), 32'd1);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_no_second_load", 32'(load_cnt), 32'(consumed));
    ack_pulse("ovr");
    repeat (4) @(posedge clock);
    #1;

    // Ack coincides with the stop sample of the next byte
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0, 10 * CPB);
    expect_load("same12");
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1, 155, 10 * CPB);
    expect_load("same34");
    chk("same_valid", 32'(valid), 32'd1);
    chk("same_overrun", 32'(overrun), 32'd0);
    chk("same_data", 32'(data), 32'h34);

    // Reset in the middle of data bit 4, with valid still set from the last byte
    send_frame(8'hAA, 1'b1, 0, 5 * CPB + 8);
    reset = 1'b1;
    #2;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    fe0 = fe_cycles;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 0, 10 * CPB);
    expect_load("ff0");
    chk("ff0_frame_err_cnt", 32'(fe_cycles - fe0), 32'd0);
    chk("ff0_overrun", 32'(overrun), 32'd0);
    ack_pulse("ff0");

    // Final scoreboard state
    repeat (10) @(posedge clock);
    #1;
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("end_no_extra_loads", 32'(load_cnt), 32'(consumed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
